frog_mem: RTL

Parametrised program/data memory responder for the FROG CPU external bus, replacing the hard-wired combinational program table with a synthesizable, loadable RAM. It sits between the CPU's multiplexed address/store-data bus and its nibble read-data input. The CPU reads instructions and operands from it and writes stores back into it. A host-side load port preloads programs, and status outputs track CPU stores and out-of-range accesses.

---
 rtl/frog_mem_if.sv | 26 ++
 rtl/frog_mem.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/frog_mem_if.sv
// FROG external bus bundle: CPU multiplexed address/store bus, host load port and status.
interface frog_mem_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 4
);
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_wcyc;
  logic [DATA_W-1:0] cpu_rdata;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              busy;
  logic [7:0]        wr_count;
  logic              oob;

  modport master (
    output cpu_addr, cpu_wcyc, ld_valid, ld_addr, ld_data,
    input  cpu_rdata, ld_ready, busy, wr_count, oob
  );

  modport slave (
    input  cpu_addr, cpu_wcyc, ld_valid, ld_addr, ld_data,
    output cpu_rdata, ld_ready, busy, wr_count, oob
  );
endinterface

// File: rtl/frog_mem.sv
// Loadable program/data RAM responding on the FROG CPU external bus.
// Define FROG_MEM_CLEAR_EN to fill the array with FILL after every reset.
module frog_mem #(
  parameter int                ADDR_W   = 7,
  parameter int                DATA_W   = 4,
  parameter int                DEPTH    = 128,
  parameter int                READ_LAT = 0,
  parameter logic [DATA_W-1:0] FILL     = 4'h8
) (
  input logic       clk,
  input logic       rst_p,
  frog_mem_if.slave bus
);

  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_PTR = IDX_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_CLEAR,
    S_RUN
  } state_e;

`ifdef FROG_MEM_CLEAR_EN
  localparam state_e RESET_STATE = S_CLEAR;
`else
  localparam state_e RESET_STATE = S_RUN;
`endif

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_C;
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q;
  logic              wcyc_prev_q;
  logic [7:0]        wr_count_q;
  logic              oob_q;
  logic [DATA_W-1:0] rdata_q;

  logic              run;
  logic              busy_s;
  logic              clear_we;
  logic              ld_ready_s;
  logic              ld_fire;
  logic              cpu_rd;
  logic              cpu_wr;
  logic [DATA_W-1:0] rd_val;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state is assigned with <= so every register samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      state_q <= RESET_STATE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      S_CLEAR: begin
        if (ptr_q == LAST_PTR) begin
          state_d = S_RUN;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = RESET_STATE;
    endcase
  end

  always_comb begin
    busy_s     = 1'b0;
    clear_we   = 1'b0;
    ld_ready_s = 1'b0;
    unique case (state_q)
      S_CLEAR: begin
`ifdef FROG_MEM_CLEAR_EN
        busy_s   = 1'b1;
`endif
        clear_we = 1'b1;
      end
      S_RUN:   ld_ready_s = ~bus.cpu_wcyc;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- Datapath
  assign run     = (state_q == S_RUN);
  assign ld_fire = bus.ld_valid & ld_ready_s;
  assign cpu_rd  = run & ~bus.cpu_wcyc;
  assign cpu_wr  = run & bus.cpu_wcyc;

  // Write-first bypass: a load landing on the address being read wins.
  always_comb begin
    rd_val = FILL;
    if (in_range(bus.cpu_addr)) begin
      if (ld_fire && (bus.ld_addr == bus.cpu_addr)) rd_val = bus.ld_data;
      else                                          rd_val = mem_q[bus.cpu_addr[IDX_W-1:0]];
    end
  end

  // CPU stores and host loads never coincide: ld_ready is low while cpu_wcyc is high.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = FILL;
    if (clear_we) begin
      mem_we    = 1'b1;
      mem_waddr = ptr_q;
    end else if (cpu_wr && in_range(addr_q)) begin
      mem_we    = 1'b1;
      mem_waddr = addr_q[IDX_W-1:0];
      mem_wdata = bus.cpu_addr[DATA_W-1:0];
    end else if (ld_fire && in_range(bus.ld_addr)) begin
      mem_we    = 1'b1;
      mem_waddr = bus.ld_addr[IDX_W-1:0];
      mem_wdata = bus.ld_data;
    end
  end

  // NOTE: the array has no reset so it maps onto RAM; clearing is done by
  // the CLEAR sweep when that feature is built in.
  always_ff @(posedge clk) begin
    if (mem_we && !rst_p) mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      addr_q      <= '0;
      wcyc_prev_q <= 1'b0;
      wr_count_q  <= '0;
      oob_q       <= 1'b0;
      rdata_q     <= FILL;
    end else begin
      wcyc_prev_q <= bus.cpu_wcyc;
      if (cpu_rd) begin
        addr_q  <= bus.cpu_addr;
        rdata_q <= rd_val;
      end else if (!run) begin
        rdata_q <= FILL;
      end
      if (cpu_wr && !wcyc_prev_q && (wr_count_q != 8'hFF)) wr_count_q <= wr_count_q + 8'd1;
      if ((cpu_rd  && !in_range(bus.cpu_addr)) ||
          (cpu_wr  && !in_range(addr_q))       ||
          (ld_fire && !in_range(bus.ld_addr)))
        oob_q <= 1'b1;
    end
  end

  // rdata_q doubles as the hold value for combinational reads during stores.
  assign bus.cpu_rdata = (READ_LAT == 0) ? (run ? (bus.cpu_wcyc ? rdata_q : rd_val) : FILL)
                                         : rdata_q;
  assign bus.ld_ready  = ld_ready_s;
  assign bus.busy      = busy_s;
  assign bus.wr_count  = wr_count_q;
  assign bus.oob       = oob_q;

endmodule
